// File: rtl/regfile_scoreboard.sv
// Scoreboard of in-flight long-latency destinations; stalls ID on RAW/WAW hazards and offers a drain handshake.
// FP register tracking is present only when REGFILE_SCOREBOARD_FP_EN is defined.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [1:0] id_use_rs,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic [4:0] id_fp_rs1,
  input  logic [4:0] id_fp_rs2,
  input  logic [4:0] id_fp_rs3,
  input  logic [2:0] id_fp_use_rs,
  input  logic [4:0] id_fp_rd,
  input  logic       id_fp_reg_write,
  input  logic       issue_valid,
  input  logic [4:0] issue_rd,
  input  logic       issue_fp,
  input  logic       cpl_valid,
  input  logic [4:0] cpl_rd,
  input  logic       cpl_fp,
  input  logic       drain_req,
  output logic       stall,
  output logic       drain_ack,
  output logic [6:0] pending_cnt,
  output logic       sb_error
);

`ifdef REGFILE_SCOREBOARD_FP_EN
  localparam logic [6:0] MAX_PEND = 7'd64;
`else
  localparam logic [6:0] MAX_PEND = 7'd32;
`endif

  logic [NUM_REGS-1:0] int_pend;
  logic [NUM_REGS-1:0] int_pend_next;
  logic [NUM_REGS-1:0] int_set;
  logic [NUM_REGS-1:0] int_clr;
  logic                issue_int;
  logic                cpl_int;
  logic                int_dup;
  logic                int_miss;
  logic                int_inc;
  logic                int_dec;
  logic                int_stall;
  logic                fp_dup;
  logic                fp_miss;
  logic                fp_inc;
  logic                fp_dec;
  logic                fp_stall;
  logic                inc;
  logic                dec;
  logic                cnt_err;
  logic [6:0]          cnt_next;

  // x0 is hard-wired, so issues and completions naming it are dropped entirely.
  assign issue_int = issue_valid && !issue_fp && (issue_rd != 5'd0);
  assign cpl_int   = cpl_valid && !cpl_fp && (cpl_rd != 5'd0);

  assign int_set       = issue_int ? (NUM_REGS'(1) << issue_rd) : '0;
  assign int_clr       = cpl_int ? (NUM_REGS'(1) << cpl_rd) : '0;
  assign int_pend_next = (int_pend & ~int_clr) | int_set;

  // A same-register issue and completion leaves the bit set, so the count moves only
  // when a bit actually changes; that keeps pending_cnt equal to the number of set bits.
  assign int_dup  = issue_int && int_pend[issue_rd];
  assign int_miss = cpl_int && !int_pend[cpl_rd];
  assign int_inc  = issue_int && !int_pend[issue_rd];
  assign int_dec  = cpl_int && int_pend[cpl_rd] && !(issue_int && (issue_rd == cpl_rd));

  assign int_stall = (id_use_rs[0] && (id_rs1 != 5'd0) && int_pend[id_rs1]) ||
                     (id_use_rs[1] && (id_rs2 != 5'd0) && int_pend[id_rs2]) ||
                     (id_reg_write && (id_rd != 5'd0) && int_pend[id_rd]);

`ifdef REGFILE_SCOREBOARD_FP_EN
  logic [NUM_REGS-1:0] fp_pend;
  logic [NUM_REGS-1:0] fp_pend_next;
  logic [NUM_REGS-1:0] fp_set;
  logic [NUM_REGS-1:0] fp_clr;
  logic                issue_fpv;
  logic                cpl_fpv;

  assign issue_fpv    = issue_valid && issue_fp;
  assign cpl_fpv      = cpl_valid && cpl_fp;
  assign fp_set       = issue_fpv ? (NUM_REGS'(1) << issue_rd) : '0;
  assign fp_clr       = cpl_fpv ? (NUM_REGS'(1) << cpl_rd) : '0;
  assign fp_pend_next = (fp_pend & ~fp_clr) | fp_set;

  assign fp_dup  = issue_fpv && fp_pend[issue_rd];
  assign fp_miss = cpl_fpv && !fp_pend[cpl_rd];
  assign fp_inc  = issue_fpv && !fp_pend[issue_rd];
  assign fp_dec  = cpl_fpv && fp_pend[cpl_rd] && !(issue_fpv && (issue_rd == cpl_rd));

  assign fp_stall = (id_fp_use_rs[0] && fp_pend[id_fp_rs1]) ||
                    (id_fp_use_rs[1] && fp_pend[id_fp_rs2]) ||
                    (id_fp_use_rs[2] && fp_pend[id_fp_rs3]) ||
                    (id_fp_reg_write && fp_pend[id_fp_rd]);

  always_ff @(posedge clk) begin
    if (!reset_n) fp_pend <= '0;
    else          fp_pend <= fp_pend_next;
  end
`else
  logic unused_fp;
  assign unused_fp = ^{id_fp_rs1, id_fp_rs2, id_fp_rs3, id_fp_use_rs, id_fp_rd, id_fp_reg_write};

  assign fp_dup   = 1'b0;
  assign fp_miss  = 1'b0;
  assign fp_inc   = 1'b0;
  assign fp_dec   = 1'b0;
  assign fp_stall = 1'b0;
`endif

  assign inc   = int_inc || fp_inc;
  assign dec   = int_dec || fp_dec;
  assign stall = int_stall || fp_stall;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_next = pending_cnt;
    cnt_err  = 1'b0;
    if (inc && !dec) begin
      if (pending_cnt == MAX_PEND) cnt_err  = 1'b1;
      else                         cnt_next = pending_cnt + 7'd1;
    end else if (dec && !inc) begin
      if (pending_cnt == 7'd0) cnt_err  = 1'b1;
      else                     cnt_next = pending_cnt - 7'd1;
    end
  end

  // NOTE: the pending bits are reset like ordinary flops; a stale bit would stall ID forever.
  // NOTE: state is written with non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      int_pend    <= '0;
      pending_cnt <= '0;
      sb_error    <= 1'b0;
      drain_ack   <= 1'b0;
    end else begin
      int_pend    <= int_pend_next;
      pending_cnt <= cnt_next;
      if (int_dup || int_miss || fp_dup || fp_miss || cnt_err) sb_error <= 1'b1;
      drain_ack   <= drain_req && (pending_cnt == 7'd0) && !issue_valid;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed literal checks plus randomized traffic
// compared every cycle against a set-based reference model.
module tb_regfile_scoreboard;

`ifdef REGFILE_SCOREBOARD_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_use_rs;
  logic       id_reg_write;
  logic [4:0] id_fp_rs1, id_fp_rs2, id_fp_rs3, id_fp_rd;
  logic [2:0] id_fp_use_rs;
  logic       id_fp_reg_write;
  logic       issue_valid, issue_fp, cpl_valid, cpl_fp, drain_req;
  logic [4:0] issue_rd, cpl_rd;
  logic       stall, drain_ack, sb_error;
  logic [6:0] pending_cnt;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NUM_REGS(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs(id_use_rs), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_fp_rs1(id_fp_rs1), .id_fp_rs2(id_fp_rs2), .id_fp_rs3(id_fp_rs3), .id_fp_use_rs(id_fp_use_rs),
    .id_fp_rd(id_fp_rd), .id_fp_reg_write(id_fp_reg_write),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_fp(issue_fp),
    .cpl_valid(cpl_valid), .cpl_rd(cpl_rd), .cpl_fp(cpl_fp),
    .drain_req(drain_req), .stall(stall), .drain_ack(drain_ack),
    .pending_cnt(pending_cnt), .sb_error(sb_error)
  );

  // Reference model: sets of outstanding registers plus sticky error and drain flag.
  bit m_int[32];
  bit m_fp[32];
  bit m_err;
  bit m_ack;
  bit chk_en = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_int[i]) + int'(m_fp[i]);
    return n;
  endfunction

  function automatic bit m_stall();
    bit s = 1'b0;
    if (id_use_rs[0] && id_rs1 != 5'd0 && m_int[id_rs1]) s = 1'b1;
    if (id_use_rs[1] && id_rs2 != 5'd0 && m_int[id_rs2]) s = 1'b1;
    if (id_reg_write && id_rd != 5'd0 && m_int[id_rd]) s = 1'b1;
    if (FP_EN) begin
      if (id_fp_use_rs[0] && m_fp[id_fp_rs1]) s = 1'b1;
      if (id_fp_use_rs[1] && m_fp[id_fp_rs2]) s = 1'b1;
      if (id_fp_use_rs[2] && m_fp[id_fp_rs3]) s = 1'b1;
      if (id_fp_reg_write && m_fp[id_fp_rd]) s = 1'b1;
    end
    return s;
  endfunction

  always @(posedge clk) begin : model
    bit oi[32];
    bit of[32];
    int cnt0;
    cnt0 = m_count();
    oi = m_int;
    of = m_fp;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_int[i] = 1'b0;
        m_fp[i]  = 1'b0;
      end
      m_err = 1'b0;
      m_ack = 1'b0;
    end else begin
      m_ack = drain_req && cnt0 == 0 && !issue_valid;
      if (cpl_valid) begin
        if (!cpl_fp && cpl_rd != 5'd0) begin
          if (!oi[cpl_rd]) m_err = 1'b1;
          m_int[cpl_rd] = 1'b0;
        end else if (cpl_fp && FP_EN) begin
          if (!of[cpl_rd]) m_err = 1'b1;
          m_fp[cpl_rd] = 1'b0;
        end
      end
      if (issue_valid) begin
        if (!issue_fp && issue_rd != 5'd0) begin
          if (oi[issue_rd]) m_err = 1'b1;
          m_int[issue_rd] = 1'b1;
        end else if (issue_fp && FP_EN) begin
          if (of[issue_rd]) m_err = 1'b1;
          m_fp[issue_rd] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_stall", 32'(stall), 32'(m_stall()));
      check("cyc_pending_cnt", 32'(pending_cnt), 32'(m_count()));
      check("cyc_sb_error", 32'(sb_error), 32'(m_err));
      check("cyc_drain_ack", 32'(drain_ack), 32'(m_ack));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs = '0; id_rd = '0; id_reg_write = 1'b0;
    id_fp_rs1 = '0; id_fp_rs2 = '0; id_fp_rs3 = '0; id_fp_use_rs = '0; id_fp_rd = '0;
    id_fp_reg_write = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_fp = 1'b0;
    cpl_valid = 1'b0; cpl_rd = '0; cpl_fp = 1'b0;
  endtask

  initial begin
    idle();
    drain_req = 1'b0;
    reset_n = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    chk_en = 1'b1;
    step();
    id_rs1 = 5'd5; id_use_rs = 2'b01;
    #1;
    check("rst_cnt", 32'(pending_cnt), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(sb_error), 32'd0);

    // Integer RAW on x5.
    reset_n = 1'b1;
    idle();
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    idle();
    id_rs1 = 5'd5; id_use_rs = 2'b01;
    #1;
    check("raw_cnt_one", 32'(pending_cnt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("raw_stall_held", 32'(stall), 32'd1);
      step();
    end
    cpl_valid = 1'b1; cpl_rd = 5'd5;
    #1;
    check("raw_stall_cpl_cycle", 32'(stall), 32'd1);
    step();
    cpl_valid = 1'b0;
    #1;
    check("raw_release", 32'(stall), 32'd0);
    check("raw_cnt_zero", 32'(pending_cnt), 32'd0);

    // x0 is never tracked.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    idle();
    id_rs1 = 5'd0; id_use_rs = 2'b01;
    #1;
    check("x0_stall", 32'(stall), 32'd0);
    check("x0_cnt", 32'(pending_cnt), 32'd0);
    check("x0_err", 32'(sb_error), 32'd0);

    // Issue f3 while completing x7 in the same cycle.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    idle();
    issue_valid = 1'b1; issue_fp = 1'b1; issue_rd = 5'd3;
    cpl_valid = 1'b1; cpl_rd = 5'd7;
    step();
    idle();
    id_rs1 = 5'd7; id_use_rs = 2'b01;
    #1;
    check("sim_x7_clear", 32'(stall), 32'd0);
    check("sim_cnt", 32'(pending_cnt), 32'(FP_EN));
    id_use_rs = 2'b00; id_fp_rs1 = 5'd3; id_fp_use_rs = 3'b001;
    #1;
    check("sim_f3_pend", 32'(stall), 32'(FP_EN));
    idle();
    cpl_valid = 1'b1; cpl_fp = 1'b1; cpl_rd = 5'd3;
    step();
    idle();
    #1;
    check("f3_done_cnt", 32'(pending_cnt), 32'd0);
    check("f3_done_err", 32'(sb_error), 32'd0);

    // FMA rs3 RAW and WAW on f0.
    issue_valid = 1'b1; issue_fp = 1'b1; issue_rd = 5'd0;
    step();
    idle();
    id_fp_rs3 = 5'd0; id_fp_use_rs = 3'b100;
    #1;
    check("fma_rs3_raw", 32'(stall), 32'(FP_EN));
    id_fp_use_rs = 3'b000; id_fp_reg_write = 1'b1; id_fp_rd = 5'd0;
    #1;
    check("fma_waw", 32'(stall), 32'(FP_EN));
    cpl_valid = 1'b1; cpl_fp = 1'b1; cpl_rd = 5'd0;
    step();
    cpl_valid = 1'b0; cpl_fp = 1'b0;
    #1;
    check("fma_release", 32'(stall), 32'd0);
    check("fma_cnt", 32'(pending_cnt), 32'd0);

    // Completion of a non-pending register is sticky.
    idle();
    cpl_valid = 1'b1; cpl_rd = 5'd9;
    step();
    idle();
    #1;
    check("err_set", 32'(sb_error), 32'd1);
    check("err_cnt", 32'(pending_cnt), 32'd0);
    step();
    step();
    check("err_sticky", 32'(sb_error), 32'd1);

    // Drain handshake, after a reset that also clears the error.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    check("drain_rst_err", 32'(sb_error), 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd1;
    step();
    issue_rd = 5'd2;
    step();
    idle();
    drain_req = 1'b1;
    #1;
    check("drain_two_cnt", 32'(pending_cnt), 32'd2);
    cpl_valid = 1'b1; cpl_rd = 5'd1;
    step();
    check("drain_ack_busy", 32'(drain_ack), 32'd0);
    cpl_rd = 5'd2;
    step();
    idle();
    #1;
    check("drain_ack_cnt0", 32'(drain_ack), 32'd0);
    check("drain_cnt0", 32'(pending_cnt), 32'd0);
    step();
    check("drain_ack_rise", 32'(drain_ack), 32'd1);
    drain_req = 1'b0;
    step();
    check("drain_ack_fall", 32'(drain_ack), 32'd0);

    // Randomized traffic with occasional protocol errors and mid-run resets.
    for (int c = 0; c < 3000; c++) begin
      int start;
      bit found;
      reset_n = ($urandom_range(0, 299) != 0);
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_use_rs = 2'($urandom);
      id_rd = 5'($urandom); id_reg_write = 1'($urandom);
      id_fp_rs1 = 5'($urandom); id_fp_rs2 = 5'($urandom); id_fp_rs3 = 5'($urandom);
      id_fp_use_rs = 3'($urandom); id_fp_rd = 5'($urandom); id_fp_reg_write = 1'($urandom);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_fp = 1'($urandom);
      issue_rd = 5'($urandom);
      if (issue_valid && (issue_fp ? m_fp[issue_rd] : m_int[issue_rd]) && $urandom_range(0, 49) != 0)
        issue_valid = 1'b0;
      cpl_valid = ($urandom_range(0, 1) == 0);
      cpl_fp = 1'($urandom);
      cpl_rd = 5'($urandom);
      if (cpl_valid && $urandom_range(0, 49) != 0) begin
        start = int'($urandom_range(0, 31));
        found = 1'b0;
        for (int k = 0; k < 32; k++) begin
          int idx;
          idx = (start + k) % 32;
          if (!found && (cpl_fp ? m_fp[idx] : (idx != 0 && m_int[idx]))) begin
            cpl_rd = 5'(idx);
            found = 1'b1;
          end
        end
        if (!found) cpl_valid = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
      step();
    end

    idle();
    reset_n = 1'b1;
    drain_req = 1'b0;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Tracks in-flight destination registers of long-latency execution units (integer divider, FP div/sqrt, FMA) and stalls the ID stage on RAW and WAW hazards that the EX/MEM and MEM/WB forwarding paths cannot cover. It sits beside the hazard detection unit. Its `stall` output is ORed into the pipeline stall. It also offers a drain handshake so that fences and CSR writes to `fcsr` can wait until every outstanding write has retired.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers per file. Fixed at 32; the index width is 5.

Ports:
- `clk`  in  1  clock; everything samples on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `id_rs1`, `id_rs2`  in  5 each  integer source registers of the instruction in ID.
- `id_use_rs`  in  2  valid bits: [0] = rs1 is used, [1] = rs2 is used.
- `id_rd`  in  5  integer destination of the instruction in ID.
- `id_reg_write`  in  1  the ID instruction writes the integer register file.
- `id_fp_rs1`, `id_fp_rs2`, `id_fp_rs3`  in  5 each  FP source registers.
- `id_fp_use_rs`  in  3  valid bits for FP rs1, rs2 and rs3.
- `id_fp_rd`  in  5  FP destination of the instruction in ID.
- `id_fp_reg_write`  in  1  the ID instruction writes the FP register file.
- `issue_valid`  in  1  a long-latency op is accepted into its unit this cycle.
- `issue_rd`  in  5  destination of the issued op.
- `issue_fp`  in  1  1 = destination is in the FP file.
- `cpl_valid`  in  1  a long-latency result is written back this cycle.
- `cpl_rd`  in  5  register being written back.
- `cpl_fp`  in  1  1 = the write-back targets the FP file.
- `drain_req`  in  1  level request to wait until nothing is outstanding.
- `stall`  out  1  combinational stall request to ID.
- `drain_ack`  out  1  registered; high while the drain condition is met.
- `pending_cnt`  out  7  registered count of outstanding writes, range 0..64.
- `sb_error`  out  1  sticky protocol-violation flag.

## Operation
- State: `int_pend[31:0]`, `fp_pend[31:0]`, `pending_cnt`, `sb_error`, `drain_ack`.
- Issue, integer (`issue_valid && !issue_fp`): sets `int_pend[issue_rd]`. An integer issue with rd = 0 is ignored and changes nothing, including the count.
- Issue, FP (`issue_valid && issue_fp`): sets `fp_pend[issue_rd]`. f0 is tracked like every other FP register.
- Completion (`cpl_valid`): clears the pending bit for `cpl_rd` in the file selected by `cpl_fp`.
- `pending_cnt` update per cycle: +1 on an effective issue, -1 on an effective completion, net 0 when both occur.
- Integer RAW stall: `int_pend[id_rs1]` with `id_use_rs[0]`, or `int_pend[id_rs2]` with `id_use_rs[1]`. rs = 0 never stalls.
- FP RAW stall: the pending bit of any FP source whose bit in `id_fp_use_rs` is set.
- WAW stall: `id_reg_write && id_rd != 0 && int_pend[id_rd]`, or `id_fp_reg_write && fp_pend[id_fp_rd]`.
- `stall` is the OR of all the above.
- Stall uses registered pending state only. A register completing in cycle M still stalls readers in cycle M; the reader is released in M+1 and receives the value through MEM/WB forwarding or the register file.
- `sb_error` is set and stays set until reset when any of these occurs:
  - an issue targets a register that is already pending;
  - a completion targets a register that is not pending;
  - the count would go above 64 or below 0.
- Behaviour when an error condition occurs:
  - Issue and completion to the same register in the same cycle: set wins and `sb_error` is set.
  - Completion to a non-pending register: the count is not decremented.
- Drain: `drain_ack` at the next edge = `drain_req && pending_cnt == 0 && !(issue_valid)`. It deasserts on the edge after `drain_req` falls or after a new issue.

## Timing
- Reset, taken at a clock edge while `reset_n` = 0: all pending bits = 0, `pending_cnt` = 0, `sb_error` = 0, `drain_ack` = 0. Reset overrides a simultaneous issue or completion.
- Issue in cycle N: bit visible from N+1, so a dependent instruction in ID at N+1 stalls.
- Completion in cycle M: bit clear from M+1.
- `stall` latency: 0 cycles from the ID inputs; 1 cycle from issue or completion.
- `drain_ack` rises 1 cycle after the count reaches 0 while `drain_req` is held.
- Reset in mid-operation discards all outstanding entries. Completions arriving afterwards for those entries raise `sb_error`. The owning units must therefore be reset together with the scoreboard.

## Configuration
- `REGFILE_SCOREBOARD_FP_EN` defined:
  - the FP pending file, FP RAW/WAW checks and FP issue/completion are present.
- Undefined:
  - `fp_pend` is not built;
  - all FP inputs are ignored;
  - issue and completion with `*_fp` = 1 change neither state nor the count;
  - the count range is 0..32.

## Test plan
- Reset: hold `reset_n` = 0 for 2 cycles with `issue_valid` = 1 -> `pending_cnt` = 0, `stall` = 0, `sb_error` = 0.
- Integer RAW: issue rd = x5 at cycle 1 and complete x5 at cycle 10, with ID rs1 = x5 from cycle 2 -> `stall` = 1 for cycles 2..10 and 0 at cycle 11; `pending_cnt` = 1 then 0.
- FP FMA rs3 RAW and WAW: issue f0; ID sees fp_rs3 = f0 -> stall. Then ID sees fp_rd = f0 with no reads -> stall, until f0 completes.
- x0 ignored: issue rd = x0, then ID reads rs1 = x0 -> no stall, `pending_cnt` = 0, `sb_error` = 0.
- Simultaneous events: issue f3 and complete x7 in one cycle (x7 pending) -> count unchanged, `fp_pend[3]` = 1, `int_pend[7]` = 0. Completing a non-pending x9 -> `sb_error` = 1 and stays 1.
- Drain: two ops outstanding with `drain_req` = 1 -> `drain_ack` = 0. After the second completion, `drain_ack` = 1 on the next cycle and 0 the cycle after `drain_req` drops.
